// File: rtl/window_rotate_sched.sv
// Keypoint queue and rotate-count sweep scheduler for window_rotate, with a credit-limited output buffer.
// Optional build macro WRS_DIR_CHECK_EN: keypoints whose main direction bin is >= 36 are discarded at LOAD.
module window_rotate_sched #(
  parameter int unsigned WIN_PIX    = 256,
  parameter int unsigned ROT_LAT    = 2,
  parameter int unsigned KQ_DEPTH   = 4,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kp_valid,
  output logic        kp_ready,
  input  logic [17:0] kp_addr,
  input  logic [5:0]  kp_dir,
  output logic [5:0]  rot_main_dir,
  output logic [17:0] rot_kp_addr,
  output logic [7:0]  rot_cnt,
  output logic        rot_en,
  input  logic [15:0] rot_addr_in,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_addr,
  output logic        pix_last,
  output logic        kp_done,
  output logic        busy,
  output logic        kp_drop
);
  localparam int unsigned KQ_AW    = $clog2(KQ_DEPTH);
  localparam int unsigned OB_AW    = $clog2(OBUF_DEPTH);
  localparam logic [7:0]  CNT_LAST = 8'(WIN_PIX - 1);
  localparam logic [7:0]  OB_CAP   = 8'(OBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DRAIN} state_t;

  state_t             r_state;
  logic               r_out_en, r_rot_en, r_kp_done, r_kp_drop;
  logic [7:0]         r_rot_cnt;
  logic [17:0]        r_rot_kp_addr;
  logic [5:0]         r_rot_main_dir;

  logic [23:0]        r_kq [KQ_DEPTH];
  logic [KQ_AW:0]     r_kq_wr, r_kq_rd;
  logic               w_kq_empty, w_kq_full, w_kq_push, w_kq_pop;
  logic [23:0]        w_kq_head;

  logic [16:0]        r_ob [OBUF_DEPTH];
  logic [OB_AW:0]     r_ob_wr, r_ob_rd, w_ob_occ;
  logic [16:0]        w_ob_head;
  logic               w_ob_push, w_pix_pop, w_last_acc;

  logic [ROT_LAT-1:0] r_sv, r_sl;
  logic [7:0]         w_inflight, w_used;
  logic               w_credit, w_bad_dir, w_issue;

  assign w_kq_empty = (r_kq_wr == r_kq_rd);
  assign w_kq_full  = (r_kq_wr[KQ_AW] != r_kq_rd[KQ_AW]) &&
                      (r_kq_wr[KQ_AW-1:0] == r_kq_rd[KQ_AW-1:0]);
  assign w_kq_head  = r_kq[r_kq_rd[KQ_AW-1:0]];

  assign w_ob_occ   = r_ob_wr - r_ob_rd;
  assign w_ob_head  = r_ob[r_ob_rd[OB_AW-1:0]];
  assign w_ob_push  = r_sv[ROT_LAT-1];
  assign w_pix_pop  = pix_valid && pix_ready;
  assign w_last_acc = w_pix_pop && w_ob_head[16];

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < ROT_LAT; i++) w_inflight = w_inflight + {7'd0, r_sv[i]};
  end

  assign w_used   = 8'(w_ob_occ) + w_inflight;
  assign w_credit = (w_used < OB_CAP);

`ifdef WRS_DIR_CHECK_EN
  assign w_bad_dir = (r_state == S_LOAD) && (r_rot_main_dir >= 6'd36);
`else
  assign w_bad_dir = 1'b0;
`endif

  // cnt 0 is issued in LOAD itself (credit is always full there) so the first pixel lands ROT_LAT+1 after LOAD
  assign w_issue  = w_credit && (((r_state == S_LOAD) && !w_bad_dir) || (r_state == S_SWEEP));
  assign w_kq_pop = !w_kq_empty && ((r_state == S_IDLE) ||
                                    ((r_state == S_LOAD) && w_bad_dir) ||
                                    ((r_state == S_DRAIN) && w_last_acc && (w_inflight == '0)));
  assign w_kq_push = kp_valid && kp_ready;

  assign kp_ready     = r_out_en && (!w_kq_full || w_kq_pop);
  assign rot_main_dir = r_rot_main_dir;
  assign rot_kp_addr  = r_rot_kp_addr;
  assign rot_cnt      = r_rot_cnt;
  assign rot_en       = r_rot_en;
  assign pix_valid    = (w_ob_occ != '0);
  assign pix_addr     = pix_valid ? w_ob_head[15:0] : '0;
  assign pix_last     = pix_valid && w_ob_head[16];
  assign kp_done      = r_kp_done;
  assign kp_drop      = r_kp_drop;
  assign busy         = (r_state != S_IDLE) || !w_kq_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_out_en       <= 1'b0;
      r_rot_en       <= 1'b0;
      r_kp_done      <= 1'b0;
      r_kp_drop      <= 1'b0;
      r_rot_cnt      <= '0;
      r_rot_kp_addr  <= '0;
      r_rot_main_dir <= '0;
    end else begin
      r_out_en  <= 1'b1;
      r_kp_done <= 1'b0;
      r_kp_drop <= 1'b0;
      case (r_state)
        S_IDLE: if (!w_kq_empty) begin
          r_state  <= S_LOAD;
          r_rot_en <= 1'b1;
        end
        S_LOAD, S_SWEEP: begin
          if (w_bad_dir) begin
            r_kp_drop <= 1'b1;
            if (w_kq_empty) begin
              r_state  <= S_IDLE;
              r_rot_en <= 1'b0;
            end
          end else if (w_issue) begin
            if (r_rot_cnt == CNT_LAST) r_state <= S_DRAIN;
            else begin
              r_rot_cnt <= r_rot_cnt + 8'd1;
              r_state   <= S_SWEEP;
            end
          end
        end
        S_DRAIN: if (w_last_acc && (w_inflight == '0)) begin
          r_kp_done <= 1'b1;
          if (w_kq_empty) begin
            r_state  <= S_IDLE;
            r_rot_en <= 1'b0;
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // every pop starts a fresh keypoint: latch it over whatever the case above chose
      if (w_kq_pop) begin
        r_rot_kp_addr  <= w_kq_head[23:6];
        r_rot_main_dir <= w_kq_head[5:0];
        r_rot_cnt      <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kq_wr <= '0;
      r_kq_rd <= '0;
      r_ob_wr <= '0;
      r_ob_rd <= '0;
      r_sv    <= '0;
      r_sl    <= '0;
    end else begin
      if (w_kq_push) r_kq_wr <= r_kq_wr + 1'b1;
      if (w_kq_pop)  r_kq_rd <= r_kq_rd + 1'b1;
      if (w_ob_push) r_ob_wr <= r_ob_wr + 1'b1;
      if (w_pix_pop) r_ob_rd <= r_ob_rd + 1'b1;
      r_sv[0] <= w_issue;
      r_sl[0] <= w_issue && (r_rot_cnt == CNT_LAST);
      for (int unsigned i = 1; i < ROT_LAT; i++) begin
        r_sv[i] <= r_sv[i-1];
        r_sl[i] <= r_sl[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_kq_push) r_kq[r_kq_wr[KQ_AW-1:0]] <= {kp_addr, kp_dir};
    if (w_ob_push) r_ob[r_ob_wr[OB_AW-1:0]] <= {r_sl[ROT_LAT-1], rot_addr_in};
  end
endmodule
